stage2_decode: RTL and testbench
================================

# stage2_decode

Instruction-decode / register-read stage of the five-stage pipeline. Consumes the IF/ID word pair from the fetch stage and produces the registered ID/EX bundle for execute. Owns the 32×32 register file, load-use hazard detection that drives the fetch stage's `hazard` input, and bubble insertion on load-use stalls and taken branches.

## Interface
- `XLEN`, 32: datapath width.
- `NREGS`, 32: architectural registers; x0 is hardwired to zero.
- `clk`  input  1  pipeline clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high.
- `if_id`  input  32×[1:0]  fetch-stage output: `[0]` = instruction, `[1]` = npc (word address).
- `branch_cond`  input  1  EX/MEM taken-branch flag; the same signal the fetch stage sees.
- `wb_en`  input  1  write-back enable.
- `wb_rd`  input  5  write-back destination.
- `wb_data`  input  XLEN  write-back value.
- `hazard`  output  1  combinational load-use stall request to the fetch stage.
- `id_ex`  output  `id_ex_t`  registered bundle: valid, npc, ir, a, b, imm, rd, reg_write, is_load, is_store, is_branch, illegal.

## Operation
- Field split: opcode = ir[6:0], rd = ir[11:7], funct3 = ir[14:12], rs1 = ir[19:15], rs2 = ir[24:20].
- Supported opcode classes: R, I-ALU, LOAD, STORE, BRANCH, LUI, JAL. Any other opcode sets `illegal`=1 and `reg_write`=0, with `valid` still 1.
- Immediates are sign-extended to XLEN from ir[31]:
  - I: ir[31:20].
  - S: {ir[31:25], ir[11:7]}.
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U: {ir[31:12], 12'b0}.
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - R-type: imm = 0.
- Register read is combinational.
  - A read of x0 returns 0 regardless of any write.
  - Write-first bypass: if `wb_en` is 1, `wb_rd`==rs, and rs≠0, the read returns `wb_data` in the same cycle.
- Register write happens on the rising edge when `wb_en`=1 and `wb_rd`≠0. A write to x0 is discarded.
- Load-use hazard:
  - `hazard` = id_ex.valid & id_ex.is_load & id_ex.rd≠0 & (id_ex.rd==rs1_used | id_ex.rd==rs2_used) & !branch_cond.
  - rs2 counts as used only for R, STORE, and BRANCH. rs1 counts as used for everything except LUI and JAL.
- Next id_ex, in priority order:
  1. `branch_cond`=1: bubble.
  2. `hazard`=1: bubble.
  3. Otherwise: the decoded instruction with valid=1.
- Bubble: every id_ex field is 0 (valid=0, reg_write=0).
- While a stall is active, fetch holds pc, so `if_id` re-presents the same instruction. It is decoded again on the following cycle, when the load is no longer in id_ex.

## Timing
- Reset (asynchronous): id_ex is all zeros and every register-file entry is 0. `hazard` is therefore 0 while reset is held.
- Latency: one cycle from `if_id` to `id_ex`.
- A load-use stall lasts exactly one cycle: one bubble, then the dependent instruction issues.
- Back-to-back load → dependent load → dependent user produces two separate one-cycle stalls.
- `branch_cond` together with `hazard`: branch wins. `hazard` is masked and a bubble is inserted. The wrong-path instruction is never issued.
- `wb_en` on the same cycle as a read of the same register: the bypassed value is captured into id_ex.a/b on that edge.
- Reset asserted mid-stall: bubble state and register file clear immediately, with no clock edge needed.
- Combinational path: `if_id` → `hazard` → fetch pc enable. This stage adds no flop on `hazard`.

## Structure
- Package `pipeline_pkg`:
  - opcode localparams (OP_R=7'h33, OP_I=7'h13, OP_LOAD=7'h03, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_LUI=7'h37, OP_JAL=7'h6F).
  - packed `id_ex_t` struct.
  - `imm_gen` function.
- Sub-module `reg_file`: 2 read ports, 1 write port, async reset, x0 forced to 0, write-first bypass inside the sub-module.
- Top level holds the decode logic, the hazard logic, and the id_ex register.

## Test plan
- Reset, then one `if_id` = {npc=1, ir=`addi x1,x0,5` (0x00500093)} → next edge: id_ex.valid=1, rd=1, imm=5, a=0, reg_write=1, hazard=0.
- With wb_en=1, wb_rd=3, wb_data=0xDEAD in the same cycle as decoding `add x4,x3,x3` → id_ex.a = id_ex.b = 0xDEAD. Then wb_rd=0, wb_data=7 → a read of x0 returns 0.
- `lw x5,0(x1)` followed by `add x6,x5,x2` → hazard=1 for exactly one cycle, id_ex bubble (valid=0), then the add issues with valid=1. Same sequence with the add's rs = x0 as the load rd → no hazard.
- Hazard condition present with branch_cond=1 in the same cycle → hazard=0 and id_ex bubble. The following instruction decodes normally.
- Instruction with opcode 7'h7F → id_ex.illegal=1, valid=1, reg_write=0.
- Reset asserted between clock edges during a stall → id_ex is zeroed and hazard=0 immediately. A read of x5 after reset returns 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: opcodes, the ID/EX bundle and immediate generation.
package pipeline_pkg;

    localparam int DW = 32;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic          valid;
        logic [31:0]   npc;
        logic [31:0]   ir;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [4:0]    rd;
        logic          reg_write;
        logic          is_load;
        logic          is_store;
        logic          is_branch;
        logic          illegal;
    } id_ex_t;

    function automatic logic [DW-1:0] imm_gen(input logic [31:0] ir);
        logic [DW-1:0] v;
        case (ir[6:0])
            OP_I, OP_LOAD: v = {{20{ir[31]}}, ir[31:20]};
            OP_STORE:      v = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH:     v = {{19{ir[31]}}, ir[31], ir[7],
                                ir[30:25], ir[11:8], 1'b0};
            OP_LUI:        v = {ir[31:12], 12'b0};
            OP_JAL:        v = {{11{ir[31]}}, ir[31], ir[19:12],
                                ir[20], ir[30:21], 1'b0};
            default:       v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/stage2_decode_reg_file.sv
// Register file: two combinational read ports with write-first bypass,
// one write port, x0 hardwired to zero.
module reg_file #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd
);

    logic [NREGS-1:0][XLEN-1:0] r_regs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regs <= '0;
        end else if (i_we && i_wa != 5'd0) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    always_comb begin
        o_rd1 = r_regs[i_rs1];
        o_rd2 = r_regs[i_rs2];
        if (i_we && i_wa == i_rs1) o_rd1 = i_wd;
        if (i_we && i_wa == i_rs2) o_rd2 = i_wd;
        if (i_rs1 == 5'd0) o_rd1 = '0;
        if (i_rs2 == 5'd0) o_rd2 = '0;
    end

endmodule

// File: rtl/stage2_decode.sv
// Decode / register-read stage: field decode, load-use hazard detection
// and the registered ID/EX bundle with bubble insertion.
module stage2_decode import pipeline_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0][31:0] if_id,
    input  logic             branch_cond,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             hazard,
    output id_ex_t           id_ex
);

    logic [31:0]     w_ir;
    logic [6:0]      w_op;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_rw;
    logic            w_ld;
    logic            w_st;
    logic            w_br;
    logic            w_ill;
    logic            w_use1;
    logic            w_use2;
    id_ex_t          w_dec;
    id_ex_t          r_id_ex;

    assign w_ir  = if_id[0];
    assign w_op  = w_ir[6:0];
    assign w_rs1 = w_ir[19:15];
    assign w_rs2 = w_ir[24:20];

    reg_file #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
        .clk   (clk),
        .reset (reset),
        .i_rs1 (w_rs1),
        .i_rs2 (w_rs2),
        .o_rd1 (w_a),
        .o_rd2 (w_b),
        .i_we  (wb_en),
        .i_wa  (wb_rd),
        .i_wd  (wb_data)
    );

    always_comb begin
        w_rw   = 1'b0;
        w_ld   = 1'b0;
        w_st   = 1'b0;
        w_br   = 1'b0;
        w_ill  = 1'b0;
        w_use1 = 1'b1;
        w_use2 = 1'b0;
        unique case (1'b1)
            (w_op == OP_R):      begin w_rw = 1'b1; w_use2 = 1'b1; end
            (w_op == OP_I):      w_rw = 1'b1;
            (w_op == OP_LOAD):   begin w_rw = 1'b1; w_ld = 1'b1; end
            (w_op == OP_STORE):  begin w_st = 1'b1; w_use2 = 1'b1; end
            (w_op == OP_BRANCH): begin w_br = 1'b1; w_use2 = 1'b1; end
            (w_op == OP_LUI):    begin w_rw = 1'b1; w_use1 = 1'b0; end
            (w_op == OP_JAL):    begin w_rw = 1'b1; w_use1 = 1'b0; end
            default:             w_ill = 1'b1;
        endcase
    end

    // A taken branch squashes this instruction, so it cannot stall.
    assign hazard = r_id_ex.valid && r_id_ex.is_load
                 && r_id_ex.rd != 5'd0
                 && ((w_use1 && r_id_ex.rd == w_rs1)
                  || (w_use2 && r_id_ex.rd == w_rs2))
                 && !branch_cond;

    always_comb begin
        w_dec           = '0;
        w_dec.valid     = 1'b1;
        w_dec.npc       = if_id[1];
        w_dec.ir        = w_ir;
        w_dec.a         = w_a;
        w_dec.b         = w_b;
        w_dec.imm       = imm_gen(w_ir);
        w_dec.rd        = w_ir[11:7];
        w_dec.reg_write = w_rw;
        w_dec.is_load   = w_ld;
        w_dec.is_store  = w_st;
        w_dec.is_branch = w_br;
        w_dec.illegal   = w_ill;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id_ex <= '0;
        end else if (branch_cond || hazard) begin
            r_id_ex <= '0;
        end else begin
            r_id_ex <= w_dec;
        end
    end

    assign id_ex = r_id_ex;

endmodule

// File: tb/tb_stage2_decode.sv
// Self-checking bench for stage2_decode: directed scenarios followed by
// random instruction streams checked against a behavioural model.
module tb_stage2_decode;
    import pipeline_pkg::*;

    logic             clk;
    logic             reset;
    logic [1:0][31:0] if_id;
    logic             branch_cond;
    logic             wb_en;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             hazard;
    id_ex_t           id_ex;

    stage2_decode #(.XLEN(32), .NREGS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_id       (if_id),
        .branch_cond (branch_cond),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .hazard      (hazard),
        .id_ex       (id_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tot  = 0;
    int          n_pass = 0;
    logic [31:0] m_regs [32];
    id_ex_t      m_q;
    logic        g_h;
    logic        g_hobs;

    task automatic chk(input string tag, input logic [199:0] obs,
                       input logic [199:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ir);
        logic [31:0] v;
        logic [6:0]  op;
        op = ir[6:0];
        v  = 0;
        if (op == 7'h13 || op == 7'h03) begin
            v = ir >> 20;
            if (ir[31]) v = v - 4096;
        end else if (op == 7'h23) begin
            v = ((ir >> 25) << 5) | ((ir >> 7) & 31);
            if (ir[31]) v = v - 4096;
        end else if (op == 7'h63) begin
            v = (((ir >> 7) & 1) << 11) | (((ir >> 25) & 63) << 5)
              | (((ir >> 8) & 15) << 1);
            if (ir[31]) v = v - 4096;
        end else if (op == 7'h37) begin
            v = ir & 32'hFFFFF000;
        end else if (op == 7'h6F) begin
            v = (((ir >> 12) & 255) << 12) | (((ir >> 20) & 1) << 11)
              | (((ir >> 21) & 1023) << 1);
            if (ir[31]) v = v - (1 << 20);
        end
        return v;
    endfunction

    function automatic id_ex_t m_decode();
        id_ex_t      e;
        logic [31:0] ir;
        logic [6:0]  op;
        ir = if_id[0];
        op = ir[6:0];
        e = '0;
        e.valid     = 1'b1;
        e.npc       = if_id[1];
        e.ir        = ir;
        e.a         = m_read(ir[19:15]);
        e.b         = m_read(ir[24:20]);
        e.imm       = m_imm(ir);
        e.rd        = ir[11:7];
        e.is_load   = (op == 7'h03);
        e.is_store  = (op == 7'h23);
        e.is_branch = (op == 7'h63);
        e.reg_write = op == 7'h33 || op == 7'h13 || op == 7'h03
                   || op == 7'h37 || op == 7'h6F;
        e.illegal   = !(e.reg_write || e.is_store || e.is_branch);
        return e;
    endfunction

    function automatic logic m_hazard();
        logic [31:0] ir;
        logic [6:0]  op;
        logic        u1;
        logic        u2;
        ir = if_id[0];
        op = ir[6:0];
        u1 = !(op == 7'h37 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return m_q.valid && m_q.is_load && m_q.rd != 0 && !branch_cond
            && ((u1 && m_q.rd == ir[19:15]) || (u2 && m_q.rd == ir[24:20]));
    endfunction

    // Called at a negedge with inputs already driven.
    task automatic step();
        id_ex_t e;
        #1;
        g_h    = m_hazard();
        g_hobs = hazard;
        chk("hazard", hazard, g_h);
        e = (branch_cond || g_h) ? id_ex_t'(0) : m_decode();
        @(posedge clk);
        if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
        m_q = e;
        #1;
        chk("id_ex", id_ex, e);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] npc,
                         input logic br, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        if_id[0]    = ir;
        if_id[1]    = npc;
        branch_cond = br;
        wb_en       = we;
        wb_rd       = wa;
        wb_data     = wd;
    endtask

    task automatic model_reset();
        m_q = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    initial begin
        logic [31:0] ir;
        logic [6:0]  ops [8];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h7F};
        model_reset();
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_id_ex", id_ex, 0);
        chk("rst_hazard", hazard, 0);
        reset = 1'b0;

        drive(32'h00500093, 32'd1, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("addi_valid", id_ex.valid, 1);
        chk("addi_imm", id_ex.imm, 5);
        chk("addi_rd", id_ex.rd, 1);
        chk("addi_rw", id_ex.reg_write, 1);

        drive(32'h00318233, 32'd2, 1'b0, 1'b1, 5'd3, 32'hDEAD);
        step();
        chk("byp_a", id_ex.a, 32'hDEAD);
        chk("byp_b", id_ex.b, 32'hDEAD);
        drive(32'h000003B3, 32'd3, 1'b0, 1'b1, 5'd0, 32'd7);
        step();
        chk("x0_read", id_ex.a, 0);

        drive(32'h0000A283, 32'd4, 1'b0, 1'b1, 5'd5, 32'h1234);
        step();
        drive(32'h00228333, 32'd5, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("lu_hz", g_hobs, 1);
        chk("lu_bubble", id_ex.valid, 0);
        step();
        chk("lu_hz_clear", g_hobs, 0);
        chk("lu_issue", id_ex.valid, 1);

        drive(32'h0000A003, 32'd6, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drive(32'h00200333, 32'd7, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("x0_nohz", g_hobs, 0);

        drive(32'h0000A283, 32'd8, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drive(32'h00228333, 32'd9, 1'b1, 1'b0, 5'd0, 32'd0);
        step();
        chk("br_mask", g_hobs, 0);
        chk("br_bubble", id_ex.valid, 0);
        drive(32'h00700493, 32'd10, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("br_next", id_ex.valid, 1);

        drive(32'h0000007F, 32'd11, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("ill_flag", id_ex.illegal, 1);
        chk("ill_valid", id_ex.valid, 1);
        chk("ill_rw", id_ex.reg_write, 0);

        drive(32'h0000A283, 32'd12, 1'b0, 1'b1, 5'd5, 32'h55);
        step();
        drive(32'h00228333, 32'd13, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("rst_pre_hz", hazard, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_id_ex", id_ex, 0);
        chk("rst_mid_hz", hazard, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(32'h00028433, 32'd14, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("rst_x5", id_ex.a, 0);

        ir = 32'h13;
        for (int c = 0; c < 400; c++) begin
            if (!g_h) begin
                ir = ($urandom() & 32'hFE007000)
                   | (32'($urandom_range(0, 7)) << 20)
                   | (32'($urandom_range(0, 7)) << 15)
                   | (32'($urandom_range(0, 7)) << 7)
                   | 32'(ops[$urandom_range(0, 7)]);
            end
            drive(ir, $urandom(), ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                  $urandom());
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
